tour_cmd_seq: RTL and testbench

Consumer end of the knight's-tour solver's replay interface. After the solver reports done, this block walks the move index 0..NUM_MOVES-1 and reads back each one-hot move. It converts each move into two motion commands: vertical leg first, then horizontal leg with fanfare. It drives these into the command processor through the cmd/cmd_rdy/clr_cmd_rdy handshake. While no tour is running, it passes UART commands straight through.

---
 rtl/tour_cmd_seq.sv | 160 ++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq.sv
// Replays a knight's tour as vertical/horizontal motion commands, or passes UART commands through when idle.
// Optional TOUR_CMD_CHK_EN: abort the tour with a tour_err_o pulse when a move is not one-hot.
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour_i,
  input  logic [7:0]  move_i,
  output logic [4:0]  indx_o,
  input  logic [15:0] cmd_uart_i,
  input  logic        cmd_rdy_uart_i,
  output logic [15:0] cmd_o,
  output logic        cmd_rdy_o,
  input  logic        clr_cmd_rdy_i,
  input  logic        send_resp_i,
  output logic [7:0]  resp_o,
  output logic        tour_active_o
`ifdef TOUR_CMD_CHK_EN
  ,
  output logic        tour_err_o
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVE     = 4'h2;
  localparam logic [3:0] OP_FANFARE  = 4'h3;
  localparam logic [7:0] HEAD_NORTH  = 8'h00;
  localparam logic [7:0] HEAD_WEST   = 8'h3F;
  localparam logic [7:0] HEAD_SOUTH  = 8'h7F;
  localparam logic [7:0] HEAD_EAST   = 8'hBF;
  localparam logic [7:0] RESP_DONE   = 8'hA5;
  localparam logic [7:0] RESP_BUSY   = 8'h5A;
  localparam logic [4:0] LAST_IDX    = 5'(NUM_MOVES - 1);

  state_t      state_q, state_d;
  logic [4:0]  indx_q, indx_d;
  logic        tour_active_q;
  logic [7:0]  resp_q;
  logic        tour_err_q;
  logic        abort_d;
  logic        move_ok;
  logic [7:0]  v_head, h_head;
  logic [3:0]  v_cnt, h_cnt;

  // Lowest set bit wins, so a zero move decodes to heading north with zero squares.
  always_comb begin
    v_head = HEAD_NORTH;
    v_cnt  = 4'd0;
    h_head = HEAD_NORTH;
    h_cnt  = 4'd0;
    casez (move_i)
      8'b???????1: begin v_head = HEAD_NORTH; v_cnt = 4'd2; h_head = HEAD_WEST; h_cnt = 4'd1; end
      8'b??????10: begin v_head = HEAD_NORTH; v_cnt = 4'd2; h_head = HEAD_EAST; h_cnt = 4'd1; end
      8'b?????100: begin v_head = HEAD_NORTH; v_cnt = 4'd1; h_head = HEAD_WEST; h_cnt = 4'd2; end
      8'b????1000: begin v_head = HEAD_SOUTH; v_cnt = 4'd1; h_head = HEAD_WEST; h_cnt = 4'd2; end
      8'b???10000: begin v_head = HEAD_SOUTH; v_cnt = 4'd2; h_head = HEAD_WEST; h_cnt = 4'd1; end
      8'b??100000: begin v_head = HEAD_SOUTH; v_cnt = 4'd2; h_head = HEAD_EAST; h_cnt = 4'd1; end
      8'b?1000000: begin v_head = HEAD_SOUTH; v_cnt = 4'd1; h_head = HEAD_EAST; h_cnt = 4'd2; end
      8'b10000000: begin v_head = HEAD_NORTH; v_cnt = 4'd1; h_head = HEAD_EAST; h_cnt = 4'd2; end
      default: ;
    endcase
  end

`ifdef TOUR_CMD_CHK_EN
  assign move_ok = (move_i != 8'd0) && ((move_i & (move_i - 8'd1)) == 8'd0);
`else
  assign move_ok = 1'b1;
`endif

  assign abort_d = (state_q == VERT) && !move_ok;

  always_comb begin
    cmd_o     = cmd_uart_i;
    cmd_rdy_o = cmd_rdy_uart_i;
    case (state_q)
      IDLE: ;
      VERT: begin
        cmd_o     = {OP_MOVE, v_head, v_cnt};
        cmd_rdy_o = move_ok;
      end
      HORZ: begin
        cmd_o     = {OP_FANFARE, h_head, h_cnt};
        cmd_rdy_o = 1'b1;
      end
      default: cmd_rdy_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    indx_d  = indx_q;
    case (state_q)
      IDLE: if (start_tour_i) begin
        state_d = VERT;
        indx_d  = 5'd0;
      end
      VERT: begin
        if (abort_d) begin
          state_d = IDLE;
          indx_d  = 5'd0;
        end else if (clr_cmd_rdy_i) begin
          state_d = WAIT_V;
        end
      end
      WAIT_V: if (send_resp_i) state_d = HORZ;
      HORZ:   if (clr_cmd_rdy_i) state_d = WAIT_H;
      WAIT_H: if (send_resp_i) begin
        if (indx_q == LAST_IDX) begin
          state_d = IDLE;
          indx_d  = 5'd0;
        end else begin
          state_d = VERT;
          indx_d  = indx_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        indx_d  = 5'd0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      indx_q        <= 5'd0;
      tour_active_q <= 1'b0;
      resp_q        <= RESP_DONE;
      tour_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      indx_q        <= indx_d;
      tour_active_q <= (state_d != IDLE);
      resp_q        <= ((state_d == IDLE) || ((state_d == WAIT_H) && (indx_d == LAST_IDX)))
                       ? RESP_DONE : RESP_BUSY;
      tour_err_q    <= abort_d;
    end
  end

  assign indx_o        = indx_q;
  assign resp_o        = resp_q;
  assign tour_active_o = tour_active_q;

`ifdef TOUR_CMD_CHK_EN
  assign tour_err_o = tour_err_q;
`else
  logic unused_err;
  assign unused_err = tour_err_q;
`endif

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: expected commands are queued at tour start, a monitor pops them on each handshake.
module tb_tour_cmd_seq;
  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour_i;
  logic [7:0]  move_i;
  logic [4:0]  indx_o;
  logic [15:0] cmd_uart_i;
  logic        cmd_rdy_uart_i;
  logic [15:0] cmd_o;
  logic        cmd_rdy_o;
  logic        clr_cmd_rdy_i;
  logic        send_resp_i;
  logic [7:0]  resp_o;
  logic        tour_active_o;
`ifdef TOUR_CMD_CHK_EN
  logic        tour_err_o;
`endif

  logic [7:0] tour_moves [32];
  assign move_i = tour_moves[indx_o];

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_tour_i   (start_tour_i),
    .move_i         (move_i),
    .indx_o         (indx_o),
    .cmd_uart_i     (cmd_uart_i),
    .cmd_rdy_uart_i (cmd_rdy_uart_i),
    .cmd_o          (cmd_o),
    .cmd_rdy_o      (cmd_rdy_o),
    .clr_cmd_rdy_i  (clr_cmd_rdy_i),
    .send_resp_i    (send_resp_i),
    .resp_o         (resp_o),
    .tour_active_o  (tour_active_o)
`ifdef TOUR_CMD_CHK_EN
    ,
    .tour_err_o     (tour_err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cmd;
    logic [4:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   handshakes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: knight displacement from the lowest set bit, turned into two legs.
  function automatic void model(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
    int b, dx, dy;
    b = -1;
    for (int i = 7; i >= 0; i--) if (m[i]) b = i;
    case (b)
      0: begin dx = -1; dy =  2; end
      1: begin dx =  1; dy =  2; end
      2: begin dx = -2; dy =  1; end
      3: begin dx = -2; dy = -1; end
      4: begin dx = -1; dy = -2; end
      5: begin dx =  1; dy = -2; end
      6: begin dx =  2; dy = -1; end
      7: begin dx =  2; dy =  1; end
      default: begin dx = 0; dy = 0; end
    endcase
    v = {4'h2, (dy < 0) ? 8'h7F : 8'h00, 4'((dy < 0) ? -dy : dy)};
    h = {4'h3, (dx > 0) ? 8'hBF : ((dx < 0) ? 8'h3F : 8'h00), 4'((dx < 0) ? -dx : dx)};
  endfunction

  task automatic push_tour(input int n);
    logic [15:0] v, h;
    for (int i = 0; i < n; i++) begin
      model(tour_moves[i], v, h);
      exp_q.push_back('{cmd: v, idx: 5'(i)});
      exp_q.push_back('{cmd: h, idx: 5'(i)});
    end
  endtask

  function automatic logic [7:0] rand_move(input bit allow_odd);
    int r;
    logic [7:0] m;
    r = $urandom_range(0, 99);
    m = 8'd1 << $urandom_range(0, 7);
    if (allow_odd && r < 12) m = 8'd0;
    else if (allow_odd && r < 30) m = 8'($urandom_range(0, 255)) | 8'd1 << $urandom_range(0, 7);
    return m;
  endfunction

  // Monitor: every accepted tour command must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && tour_active_o && cmd_rdy_o && clr_cmd_rdy_i) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got cmd %h with empty scoreboard", cmd_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_cmd", 32'(cmd_o), 32'(mon_e.cmd));
        chk("sb_indx", 32'(indx_o), 32'(mon_e.idx));
      end
    end
  end

  task automatic serve_leg(input int idx, input bit horiz, input int pre, input bit do_resp);
    int n;
    n = 0;
    while (!cmd_rdy_o && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_rdy_o) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got cmd_rdy 0 expected 1 for move %0d", idx);
      return;
    end
    chk("leg_resp", 32'(resp_o), 32'h5A);
    repeat (pre) tick();
    clr_cmd_rdy_i = 1'b1;
    tick();
    clr_cmd_rdy_i = 1'b0;
    cmd_rdy_uart_i = 1'($urandom_range(0, 1));
    chk("wait_no_rdy", 32'(cmd_rdy_o), 32'h0);
    if (do_resp) begin
      repeat ($urandom_range(1, 4)) tick();
      chk("wait_resp", 32'(resp_o), (horiz && idx == NUM_MOVES - 1) ? 32'hA5 : 32'h5A);
      send_resp_i = 1'b1;
      tick();
      send_resp_i = 1'b0;
      cmd_rdy_uart_i = 1'b0;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] v, h;
    rst = 1'b1;
    start_tour_i = 1'b0;
    cmd_uart_i = 16'h1234;
    cmd_rdy_uart_i = 1'b0;
    clr_cmd_rdy_i = 1'b0;
    send_resp_i = 1'b0;
    for (int i = 0; i < 32; i++) tour_moves[i] = 8'h01;

    #12;
    chk("rst_indx", 32'(indx_o), 32'h0);
    chk("rst_active", 32'(tour_active_o), 32'h0);
    chk("rst_resp", 32'(resp_o), 32'hA5);
    chk("rst_cmd", 32'(cmd_o), 32'h1234);
    #1 rst = 1'b0;
    tick();

    cmd_uart_i = 16'h4000;
    cmd_rdy_uart_i = 1'b1;
    #1;
    chk("pass_cmd", 32'(cmd_o), 32'h4000);
    chk("pass_rdy", 32'(cmd_rdy_o), 32'h1);
    chk("pass_active", 32'(tour_active_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmd_uart_i = 16'($urandom);
      cmd_rdy_uart_i = 1'($urandom_range(0, 1));
      #1;
      chk("pass_rand_cmd", 32'(cmd_o), 32'(cmd_uart_i));
      chk("pass_rand_rdy", 32'(cmd_rdy_o), 32'(cmd_rdy_uart_i));
    end

    // Directed tour: first moves from the worked examples, then interrupted by reset at move 7.
    tour_moves[0] = 8'h01;
    tour_moves[1] = 8'h80;
    tour_moves[2] = 8'h10;
    for (int i = 3; i < 8; i++) tour_moves[i] = rand_move(1'b0);
    push_tour(8);
    tick();
    cmd_uart_i = 16'hABCD;
    cmd_rdy_uart_i = 1'b1;
    start_tour_i = 1'b1;
    #1;
    chk("start_cycle_cmd", 32'(cmd_o), 32'hABCD);
    chk("start_cycle_active", 32'(tour_active_o), 32'h0);
    tick();
    start_tour_i = 1'b0;
    cmd_rdy_uart_i = 1'b0;
    #1;
    chk("tour_active", 32'(tour_active_o), 32'h1);
    chk("first_vert_cmd", 32'(cmd_o), 32'h2002);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        model(tour_moves[3], v, h);
        for (int c = 0; c < 20; c++) begin
          start_tour_i = (c % 5 == 0);
          send_resp_i = (c % 3 == 0);
          cmd_rdy_uart_i = 1'(c);
          tick();
          chk("hold_cmd", 32'(cmd_o), 32'(v));
          chk("hold_rdy", 32'(cmd_rdy_o), 32'h1);
          chk("hold_indx", 32'(indx_o), 32'h3);
        end
        start_tour_i = 1'b0;
        send_resp_i = 1'b0;
        cmd_rdy_uart_i = 1'b0;
      end
      serve_leg(i, 1'b0, $urandom_range(0, 2), 1'b1);
      serve_leg(i, 1'b1, $urandom_range(0, 2), (i < 7));
    end
    cmd_uart_i = 16'h1234;
    cmd_rdy_uart_i = 1'b0;
    chk("pre_rst_indx", 32'(indx_o), 32'h7);
    #3 rst = 1'b1;
    #1;
    chk("midrst_indx", 32'(indx_o), 32'h0);
    chk("midrst_active", 32'(tour_active_o), 32'h0);
    chk("midrst_resp", 32'(resp_o), 32'hA5);
    chk("midrst_cmd", 32'(cmd_o), 32'h1234);
    cmd_rdy_uart_i = 1'b1;
    #1;
    chk("midrst_rdy", 32'(cmd_rdy_o), 32'h1);
    @(posedge clk);
    #3 rst = 1'b0;
    cmd_rdy_uart_i = 1'b0;
    chk("sb_drained_directed", 32'(exp_q.size()), 32'h0);

    // Full randomized tour with a responsive command processor.
`ifdef TOUR_CMD_CHK_EN
    for (int i = 0; i < NUM_MOVES; i++) tour_moves[i] = rand_move(1'b0);
`else
    for (int i = 0; i < NUM_MOVES; i++) tour_moves[i] = rand_move(1'b1);
`endif
    push_tour(NUM_MOVES);
    handshakes = 0;
    tick();
    start_tour_i = 1'b1;
    tick();
    start_tour_i = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      serve_leg(i, 1'b0, $urandom_range(0, 3), 1'b1);
      serve_leg(i, 1'b1, $urandom_range(0, 3), 1'b1);
    end
    chk("end_active", 32'(tour_active_o), 32'h0);
    chk("end_indx", 32'(indx_o), 32'h0);
    chk("end_resp", 32'(resp_o), 32'hA5);
    chk("handshakes", 32'(handshakes), 32'(2 * NUM_MOVES));
    chk("sb_drained_full", 32'(exp_q.size()), 32'h0);

`ifdef TOUR_CMD_CHK_EN
    tour_moves[0] = 8'h03;
    tick();
    start_tour_i = 1'b1;
    tick();
    start_tour_i = 1'b0;
    chk("err_no_rdy", 32'(cmd_rdy_o), 32'h0);
    chk("err_pre", 32'(tour_err_o), 32'h0);
    tick();
    chk("err_pulse", 32'(tour_err_o), 32'h1);
    chk("err_idle", 32'(tour_active_o), 32'h0);
    chk("err_indx", 32'(indx_o), 32'h0);
    tick();
    chk("err_clear", 32'(tour_err_o), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
